// File: rtl/rtc_timekeeper_pkg.sv
// Shared definitions for the RTC timekeeper: register map, ctrl bit positions,
// BCD field limits and a BCD range check used by the write port.
package rtc_timekeeper_pkg;

  typedef enum logic [2:0] {
    ADDR_SEC    = 3'd0,
    ADDR_MIN    = 3'd1,
    ADDR_HR     = 3'd2,
    ADDR_AL_SEC = 3'd3,
    ADDR_AL_MIN = 3'd4,
    ADDR_AL_HR  = 3'd5,
    ADDR_CTRL   = 3'd6,
    ADDR_CLRDAY = 3'd7
  } reg_addr_e;

  localparam int CTRL_ALARM_EN = 0;
  localparam int CTRL_RUN      = 1;

  localparam logic [7:0] SEC_MAX = 8'h59;
  localparam logic [7:0] MIN_MAX = 8'h59;
  localparam logic [7:0] HR_MAX  = 8'h23;

  // A well-formed BCD pair orders the same as binary, so the upper bound is a plain compare.
  function automatic logic bcd_valid(input logic [7:0] v, input logic [7:0] max);
    return (v[3:0] <= 4'd9) && (v[7:4] <= max[7:4]) && (v <= max);
  endfunction

endpackage

// File: rtl/rtc_timekeeper_bcd_digit_pair_ctr.sv
// Two-digit BCD counter that wraps at MAX to 00 and flags the wrap as a carry.
// Load takes priority over increment.
module bcd_digit_pair_ctr #(
  parameter logic [7:0] MAX = 8'h59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc_i,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  output logic [7:0] val_o,
  output logic       carry_o
);

  logic [7:0] val_q, val_d;

  always_comb begin
    val_d = val_q;
    if (load_i) begin
      val_d = load_val_i;
    end else if (inc_i) begin
      if (val_q == MAX)
        val_d = 8'h00;
      else if (val_q[3:0] == 4'd9)
        val_d = {val_q[7:4] + 4'd1, 4'd0};
      else
        val_d = {val_q[7:4], val_q[3:0] + 4'd1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) val_q <= 8'h00;
    else     val_q <= val_d;
  end

  assign val_o   = val_q;
  assign carry_o = inc_i && !load_i && (val_q == MAX);

endmodule

// File: rtl/rtc_timekeeper.sv
// Time-of-day keeper: BCD hh:mm:ss plus binary day count, register writes,
// coherent snapshot readout and a sticky alarm flag.
module rtc_timekeeper
  import rtc_timekeeper_pkg::*;
#(
  parameter int DAY_WIDTH  = 16,
  parameter bit RUN_AT_RST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 one_hz,
  input  logic                 wr_en,
  input  logic [2:0]           wr_addr,
  input  logic [7:0]           wr_data,
  output logic                 wr_err,
  input  logic                 snap_req,
  output logic                 snap_valid,
  output logic [7:0]           snap_sec,
  output logic [7:0]           snap_min,
  output logic [7:0]           snap_hr,
  output logic [DAY_WIDTH-1:0] snap_days,
  output logic                 alarm_irq,
  input  logic                 alarm_ack
);

  localparam logic [DAY_WIDTH-1:0] DAY_ONE = 1;

  logic                 tick_pend_q, tick_pend_d;
  logic                 inc_done_q;
  logic                 run_q, run_d;
  logic                 alarm_en_q, alarm_en_d;
  logic [7:0]           al_sec_q, al_sec_d, al_min_q, al_min_d, al_hr_q, al_hr_d;
  logic [DAY_WIDTH-1:0] days_q, days_d;
  logic                 alarm_irq_q, alarm_irq_d;
  logic                 wr_err_q, wr_err_d;
  logic                 snap_valid_q;
  logic [7:0]           snap_sec_q, snap_min_q, snap_hr_q;
  logic [DAY_WIDTH-1:0] snap_days_q;

  logic       tick_any, inc_now;
  logic       ok59, ok23;
  logic       ld_sec, ld_min, ld_hr;
  logic [7:0] sec_val, min_val, hr_val;
  logic       sec_carry, min_carry, hr_carry;
  logic       alarm_match;

  // A tick that collides with a write is deferred one cycle so no second is lost.
  assign tick_any    = (one_hz && run_q) || tick_pend_q;
  assign inc_now     = tick_any && !wr_en;
  assign tick_pend_d = tick_any && wr_en;

  assign ok59   = bcd_valid(wr_data, SEC_MAX);
  assign ok23   = bcd_valid(wr_data, HR_MAX);
  assign ld_sec = wr_en && (wr_addr == ADDR_SEC) && ok59;
  assign ld_min = wr_en && (wr_addr == ADDR_MIN) && ok59;
  assign ld_hr  = wr_en && (wr_addr == ADDR_HR)  && ok23;

  bcd_digit_pair_ctr #(.MAX(SEC_MAX)) u_sec (
    .clk(clk), .rst(rst), .inc_i(inc_now), .load_i(ld_sec), .load_val_i(wr_data),
    .val_o(sec_val), .carry_o(sec_carry)
  );

  bcd_digit_pair_ctr #(.MAX(MIN_MAX)) u_min (
    .clk(clk), .rst(rst), .inc_i(sec_carry), .load_i(ld_min), .load_val_i(wr_data),
    .val_o(min_val), .carry_o(min_carry)
  );

  bcd_digit_pair_ctr #(.MAX(HR_MAX)) u_hr (
    .clk(clk), .rst(rst), .inc_i(min_carry), .load_i(ld_hr), .load_val_i(wr_data),
    .val_o(hr_val), .carry_o(hr_carry)
  );

  // Alarm compares the time one edge after a tick-driven increment only.
  assign alarm_match = inc_done_q && alarm_en_q &&
                       (sec_val == al_sec_q) && (min_val == al_min_q) && (hr_val == al_hr_q);

  always_comb begin
    run_d       = run_q;
    alarm_en_d  = alarm_en_q;
    al_sec_d    = al_sec_q;
    al_min_d    = al_min_q;
    al_hr_d     = al_hr_q;
    days_d      = hr_carry ? days_q + DAY_ONE : days_q;
    wr_err_d    = 1'b0;
    alarm_irq_d = alarm_match || (alarm_irq_q && !alarm_ack);
    if (wr_en) begin
      case (reg_addr_e'(wr_addr))
        ADDR_SEC, ADDR_MIN: wr_err_d = !ok59;
        ADDR_HR:            wr_err_d = !ok23;
        ADDR_AL_SEC: if (ok59) al_sec_d = wr_data; else wr_err_d = 1'b1;
        ADDR_AL_MIN: if (ok59) al_min_d = wr_data; else wr_err_d = 1'b1;
        ADDR_AL_HR:  if (ok23) al_hr_d  = wr_data; else wr_err_d = 1'b1;
        ADDR_CTRL: begin
          alarm_en_d = wr_data[CTRL_ALARM_EN];
          run_d      = wr_data[CTRL_RUN];
        end
        ADDR_CLRDAY: days_d = '0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_pend_q  <= 1'b0;
      inc_done_q   <= 1'b0;
      run_q        <= RUN_AT_RST;
      alarm_en_q   <= 1'b0;
      al_sec_q     <= 8'h00;
      al_min_q     <= 8'h00;
      al_hr_q      <= 8'h00;
      days_q       <= '0;
      alarm_irq_q  <= 1'b0;
      wr_err_q     <= 1'b0;
      snap_valid_q <= 1'b0;
      snap_sec_q   <= 8'h00;
      snap_min_q   <= 8'h00;
      snap_hr_q    <= 8'h00;
      snap_days_q  <= '0;
    end else begin
      tick_pend_q  <= tick_pend_d;
      inc_done_q   <= inc_now;
      run_q        <= run_d;
      alarm_en_q   <= alarm_en_d;
      al_sec_q     <= al_sec_d;
      al_min_q     <= al_min_d;
      al_hr_q      <= al_hr_d;
      days_q       <= days_d;
      alarm_irq_q  <= alarm_irq_d;
      wr_err_q     <= wr_err_d;
      snap_valid_q <= snap_req;
      if (snap_req) begin
        snap_sec_q  <= sec_val;
        snap_min_q  <= min_val;
        snap_hr_q   <= hr_val;
        snap_days_q <= days_q;
      end
    end
  end

  assign wr_err     = wr_err_q;
  assign snap_valid = snap_valid_q;
  assign snap_sec   = snap_sec_q;
  assign snap_min   = snap_min_q;
  assign snap_hr    = snap_hr_q;
  assign snap_days  = snap_days_q;
  assign alarm_irq  = alarm_irq_q;

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Directed bench for rtc_timekeeper; a narrow day counter makes the day wrap reachable.
module tb_rtc_timekeeper;

  localparam int DW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          one_hz = 1'b0;
  logic          wr_en = 1'b0;
  logic [2:0]    wr_addr = 3'd0;
  logic [7:0]    wr_data = 8'h00;
  logic          wr_err;
  logic          snap_req = 1'b0;
  logic          snap_valid;
  logic [7:0]    snap_sec, snap_min, snap_hr;
  logic [DW-1:0] snap_days;
  logic          alarm_irq;
  logic          alarm_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  rtc_timekeeper #(.DAY_WIDTH(DW), .RUN_AT_RST(1'b1)) dut (
    .clk(clk), .rst(rst), .one_hz(one_hz),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err),
    .snap_req(snap_req), .snap_valid(snap_valid),
    .snap_sec(snap_sec), .snap_min(snap_min), .snap_hr(snap_hr), .snap_days(snap_days),
    .alarm_irq(alarm_irq), .alarm_ack(alarm_ack)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs starting just after a falling edge.
  task automatic applyStimulus(input logic w, input logic [2:0] a, input logic [7:0] d,
                               input logic t, input logic s, input logic k);
    wr_en = w; wr_addr = a; wr_data = d; one_hz = t; snap_req = s; alarm_ack = k;
    @(negedge clk);
    wr_en = 1'b0; one_hz = 1'b0; snap_req = 1'b0; alarm_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic writeReg(input logic [2:0] a, input logic [7:0] d);
    applyStimulus(1'b1, a, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tickIdle(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0);
      idle(1);
    end
  endtask

  task automatic readTime(input string tag, input logic [7:0] s, input logic [7:0] m,
                          input logic [7:0] h, input logic [DW-1:0] d);
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0);
    checkOutput({tag, ".valid"}, {31'd0, snap_valid}, 32'd1);
    checkOutput({tag, ".sec"}, {24'd0, snap_sec}, {24'd0, s});
    checkOutput({tag, ".min"}, {24'd0, snap_min}, {24'd0, m});
    checkOutput({tag, ".hr"}, {24'd0, snap_hr}, {24'd0, h});
    checkOutput({tag, ".days"}, {30'd0, snap_days}, {30'd0, d});
  endtask

  initial begin
    idle(3);
    checkOutput("rst.snap_valid", {31'd0, snap_valid}, 32'd0);
    checkOutput("rst.wr_err", {31'd0, wr_err}, 32'd0);
    checkOutput("rst.alarm_irq", {31'd0, alarm_irq}, 32'd0);
    checkOutput("rst.snap", {snap_sec, snap_min, snap_hr, 6'd0, snap_days}, 32'd0);
    rst = 1'b0;
    idle(1);

    $display("[TB] 60 ticks from reset");
    tickIdle(60);
    readTime("t1", 8'h00, 8'h01, 8'h00, 2'd0);
    checkOutput("t1.wr_err", {31'd0, wr_err}, 32'd0);

    $display("[TB] midnight rollover and day wrap");
    for (int i = 1; i <= 5; i++) begin
      writeReg(3'd2, 8'h23);
      writeReg(3'd1, 8'h59);
      writeReg(3'd0, 8'h59);
      tickIdle(1);
      readTime($sformatf("t2.day%0d", i), 8'h00, 8'h00, 8'h00, DW'(i % 4));
    end
    writeReg(3'd7, 8'hFF);
    readTime("t2.clr", 8'h00, 8'h00, 8'h00, 2'd0);

    $display("[TB] write/tick collision and invalid writes");
    applyStimulus(1'b1, 3'd0, 8'h42, 1'b1, 1'b0, 1'b0);
    checkOutput("t3.coll_err", {31'd0, wr_err}, 32'd0);
    idle(1);
    readTime("t3.coll", 8'h43, 8'h00, 8'h00, 2'd0);
    writeReg(3'd0, 8'h5A);
    checkOutput("t3.err5A", {31'd0, wr_err}, 32'd1);
    idle(1);
    checkOutput("t3.err_pulse", {31'd0, wr_err}, 32'd0);
    writeReg(3'd0, 8'h60);
    checkOutput("t3.err60", {31'd0, wr_err}, 32'd1);
    writeReg(3'd2, 8'h24);
    checkOutput("t3.errhr24", {31'd0, wr_err}, 32'd1);
    readTime("t3.unch", 8'h43, 8'h00, 8'h00, 2'd0);

    $display("[TB] alarm");
    writeReg(3'd0, 8'h00);
    writeReg(3'd3, 8'h05);
    writeReg(3'd4, 8'h00);
    writeReg(3'd5, 8'h00);
    writeReg(3'd6, 8'h03);
    tickIdle(4);
    checkOutput("t4.pre", {31'd0, alarm_irq}, 32'd0);
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("t4.lat", {31'd0, alarm_irq}, 32'd0);
    idle(1);
    checkOutput("t4.fire", {31'd0, alarm_irq}, 32'd1);
    idle(2);
    checkOutput("t4.sticky", {31'd0, alarm_irq}, 32'd1);
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("t4.ack", {31'd0, alarm_irq}, 32'd0);
    writeReg(3'd0, 8'h04);
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("t4.setwins", {31'd0, alarm_irq}, 32'd1);
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("t4.ack2", {31'd0, alarm_irq}, 32'd0);
    writeReg(3'd0, 8'h05);
    idle(3);
    checkOutput("t4.wr_nofire", {31'd0, alarm_irq}, 32'd0);

    $display("[TB] snapshot coincident with tick");
    writeReg(3'd6, 8'h02);
    writeReg(3'd0, 8'h09);
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 1'b0);
    checkOutput("t5.valid", {31'd0, snap_valid}, 32'd1);
    checkOutput("t5.sec", {24'd0, snap_sec}, 32'h09);
    idle(1);
    checkOutput("t5.valid_pulse", {31'd0, snap_valid}, 32'd0);
    readTime("t5.live", 8'h10, 8'h00, 8'h00, 2'd0);

    $display("[TB] reset with pending tick, run=0");
    applyStimulus(1'b1, 3'd0, 8'h30, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    readTime("t6.rst", 8'h00, 8'h00, 8'h00, 2'd0);
    writeReg(3'd6, 8'h00);
    tickIdle(10);
    readTime("t6.stop", 8'h00, 8'h00, 8'h00, 2'd0);
    writeReg(3'd6, 8'h02);
    tickIdle(1);
    readTime("t6.resume", 8'h01, 8'h00, 8'h00, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
